// File: rtl/psram_bridge_pkg.sv
// Shared definitions for the AXI4 -> Wishbone PSRAM bridge.
// Contents: FSM state codes, AXI response and burst encodings, and a helper
// that flags burst types the bridge refuses to issue on Wishbone.
package psram_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_W_WAIT = 3'd1;
  localparam state_t S_WB_WR  = 3'd2;
  localparam state_t S_B_RESP = 3'd3;
  localparam state_t S_WB_RD  = 3'd4;
  localparam state_t S_R_SEND = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // WRAP and the reserved code both have bit 1 set; neither reaches the PSRAM.
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/psram_axi_wb_bridge_if.sv
// AXI4 slave-side bus bundle for the PSRAM bridge (32-bit data).
// Channels: AW, W, B, AR, R.
// Modports: slave  - the bridge (accepts addresses/data, returns responses)
//           master - the CPU-side interconnect or a testbench driver
interface psram_axi_wb_bridge_if #(
  parameter int ID_W = 4
) ();
  import psram_bridge_pkg::*;

  logic            awvalid, awready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wvalid, wready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic            arvalid, arready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid, rready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

endinterface

// File: rtl/psram_axi_burst_addr.sv
// Next-beat address for an AXI burst.
// Ports: addr_i (current beat address), size_i (AxSIZE), burst_i (AxBURST),
//        next_addr_o (address of the following beat).
// INCR steps by 1<<size, capped at 4 bytes for the 32-bit bus, with plain
// 32-bit wrap-around (no 4 KB boundary handling). Anything else holds.
module psram_axi_burst_addr
  import psram_bridge_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o
);

  logic [31:0] step;

  always_comb begin
    step = 32'd4;
    if (size_i < 3'd2) step = 32'd1 << size_i;
    next_addr_o = (burst_i == BURST_INCR) ? addr_i + step : addr_i;
  end

endmodule

// File: rtl/psram_axi_wb_bridge.sv
// AXI4 slave -> Wishbone classic master bridge in front of the PSRAM controller.
// Each AXI beat becomes one Wishbone cycle; one AXI transaction at a time.
// Ports:
//   clk_i, rst_i     clock, async active-high reset (shared with controller)
//   axi              AXI4 slave channels (psram_axi_wb_bridge_if.slave)
//   cyc_o/stb_o/we_o Wishbone cycle, strobe, write enable (registered)
//   adr_o            word-aligned address
//   dat_o, sel_o     write data and byte lanes (sel 4'b1111 on reads)
//   dat_i, ack_i     read data and cycle completion from the controller
module psram_axi_wb_bridge
  import psram_bridge_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  psram_axi_wb_bridge_if.slave  axi,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [31:0]           adr_o,
  output logic [31:0]           dat_o,
  output logic [3:0]            sel_o,
  input  logic [31:0]           dat_i,
  input  logic                  ack_i
);

  state_t state_q, state_d;
  logic   prio_q, prio_d;            // 0: read wins the next AW/AR collision
  logic   awready_q, awready_d;
  logic   arready_q, arready_d;
  logic   wready_q, wready_d;
  logic   bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic   rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic   rlast_q, rlast_d;

  logic [ID_W-1:0] id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;         // wlast disagreed with the beat count

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  logic [31:0] next_addr;
  logic [7:0]  cnt_nxt;
  logic        last_beat;
  logic        bad_burst;

  psram_axi_burst_addr u_addr (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign cnt_nxt   = cnt_q + 8'd1;
  assign last_beat = (cnt_q == len_q);
  assign bad_burst = burst_unsupported(burst_q);

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    awready_d = awready_q;
    arready_d = arready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;

    case (state_q)
      S_IDLE: begin
        if (arready_q && axi.arvalid) begin
          arready_d = 1'b0;
          id_d      = axi.arid;
          addr_d    = axi.araddr;
          len_d     = axi.arlen;
          size_d    = axi.arsize;
          burst_d   = axi.arburst;
          cnt_d     = 8'd0;
          if (burst_unsupported(axi.arburst)) begin
            // Refused burst: answer directly with zero data, no PSRAM access.
            state_d  = S_R_SEND;
            rvalid_d = 1'b1;
            rdata_d  = 32'd0;
            rresp_d  = AXI_RESP_SLVERR;
            rlast_d  = (axi.arlen == 8'd0);
          end else begin
            state_d = S_WB_RD;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = 4'b1111;
            adr_d   = {axi.araddr[31:2], 2'b00};
          end
        end else if (awready_q && axi.awvalid) begin
          awready_d = 1'b0;
          id_d      = axi.awid;
          addr_d    = axi.awaddr;
          len_d     = axi.awlen;
          size_d    = axi.awsize;
          burst_d   = axi.awburst;
          cnt_d     = 8'd0;
          err_d     = 1'b0;
          state_d   = S_W_WAIT;
          wready_d  = 1'b1;
        end else if (!arready_q && !awready_q) begin
          // Grant is registered; once a ready is raised it is held until the
          // handshake, which AXI valid-stability guarantees will come.
          if (axi.arvalid && axi.awvalid) begin
            if (prio_q) awready_d = 1'b1;
            else        arready_d = 1'b1;
            prio_d = ~prio_q;
          end else if (axi.arvalid) begin
            arready_d = 1'b1;
          end else if (axi.awvalid) begin
            awready_d = 1'b1;
          end
        end
      end

      S_W_WAIT: begin
        if (axi.wvalid && wready_q) begin
          wready_d = 1'b0;
          err_d    = err_q | (axi.wlast != last_beat);
          // A zero strobe must not reach the controller (it would write the
          // full word), so such beats complete without a Wishbone cycle.
          if (bad_burst || (axi.wstrb == 4'b0000)) begin
            if (last_beat) begin
              state_d  = S_B_RESP;
              bvalid_d = 1'b1;
              bresp_d  = (bad_burst || err_d) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else begin
              cnt_d    = cnt_nxt;
              addr_d   = next_addr;
              wready_d = 1'b1;
            end
          end else begin
            state_d = S_WB_WR;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = {addr_q[31:2], 2'b00};
            dat_d   = axi.wdata;
            sel_d   = axi.wstrb;
          end
        end
      end

      S_WB_WR: begin
        if (cyc_q && ack_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (last_beat) begin
            state_d  = S_B_RESP;
            bvalid_d = 1'b1;
            bresp_d  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          end else begin
            state_d  = S_W_WAIT;
            cnt_d    = cnt_nxt;
            addr_d   = next_addr;
            wready_d = 1'b1;
          end
        end
      end

      S_B_RESP: begin
        if (axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_WB_RD: begin
        if (cyc_q && ack_i) begin
          cyc_d    = 1'b0;
          state_d  = S_R_SEND;
          rvalid_d = 1'b1;
          rdata_d  = dat_i;
          rresp_d  = AXI_RESP_OKAY;
          rlast_d  = last_beat;
        end
      end

      S_R_SEND: begin
        if (axi.rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            cnt_d  = cnt_nxt;
            addr_d = next_addr;
            if (bad_burst) begin
              rvalid_d = 1'b1;
              rdata_d  = 32'd0;
              rresp_d  = AXI_RESP_SLVERR;
              rlast_d  = (cnt_nxt == len_q);
            end else begin
              state_d = S_WB_RD;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              sel_d   = 4'b1111;
              adr_d   = {next_addr[31:2], 2'b00};
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Async reset so cyc drops immediately alongside the controller's reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      id_q      <= '0;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
    end
  end

  assign axi.awready = awready_q;
  assign axi.arready = arready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = id_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = id_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o  = we_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign sel_o = sel_q;

endmodule

// File: tb/tb_psram_axi_wb_bridge.sv
// Self-checking bench for psram_axi_wb_bridge: AXI master driver tasks, a
// Wishbone slave responder with random ack latency, and a transaction-level
// reference model of the expected Wishbone cycles and AXI responses.
module tb_psram_axi_wb_bridge;
  import psram_bridge_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i;

  always #5 clk_i = ~clk_i;

  psram_axi_wb_bridge_if #(.ID_W(4)) axi ();

  psram_axi_wb_bridge #(.ID_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .axi   (axi),
    .cyc_o (cyc_o),
    .stb_o (stb_o),
    .we_o  (we_o),
    .adr_o (adr_o),
    .dat_o (dat_o),
    .sel_o (sel_o),
    .dat_i (dat_i),
    .ack_i (ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdat;
  } wb_rec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_rec_t;

  wb_rec_t     wb_log[$];
  r_rec_t      r_log[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic        wq_last[$];

  int n_chk  = 0;
  int n_pass = 0;
  int ack_min = 0;
  int ack_max = 4;

  logic       b_seen;
  logic [1:0] b_resp_got;
  logic [3:0] b_id_got;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- Wishbone slave responder ----------------
  initial begin
    ack_i = 1'b0;
    dat_i = 32'd0;
    forever begin
      @(posedge clk_i); #1;
      if (cyc_o && stb_o) begin
        wb_rec_t e;
        int      d;
        bit      ok;
        e.adr = adr_o; e.we = we_o; e.sel = sel_o; e.dat = dat_o; e.rdat = 32'd0;
        d  = $urandom_range(ack_max, ack_min);
        ok = 1'b1;
        for (int k = 0; k < d; k++) begin
          @(posedge clk_i); #1;
          if (!cyc_o) begin ok = 1'b0; break; end
          chk("wb_hold_adr_dat", {adr_o, dat_o}, {e.adr, e.dat});
          chk("wb_hold_sel_we", {sel_o, we_o}, {e.sel, e.we});
        end
        if (ok) begin
          dat_i  = $urandom;
          ack_i  = 1'b1;
          e.rdat = dat_i;
          wb_log.push_back(e);
          @(posedge clk_i); #1;
          ack_i = 1'b0;
          chk("cyc_drop_after_ack", {cyc_o, stb_o}, 2'b00);
          if (!e.we) chk("rvalid_after_ack", axi.rvalid, 1'b1);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] beat_adr(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst, input int i);
    int unsigned step;
    logic [31:0] x;
    step = (size > 3'd2) ? 4 : (1 << size);
    x = (burst == BURST_INCR) ? a + i * step : a;
    return {x[31:2], 2'b00};
  endfunction

  task automatic check_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit bad, err;
    int k;
    bad = burst[1];
    err = 1'b0;
    k   = 0;
    for (int i = 0; i <= len; i++)
      if (wq_last[i] != (i == len)) err = 1'b1;
    for (int i = 0; i <= len; i++) begin
      if (!bad && wq_strb[i] != 4'd0) begin
        if (k < wb_log.size()) begin
          chk("wr_adr", wb_log[k].adr, beat_adr(a, size, burst, i));
          chk("wr_sel_we", {wb_log[k].sel, wb_log[k].we}, {wq_strb[i], 1'b1});
          chk("wr_dat", wb_log[k].dat, wq_data[i]);
        end
        k++;
      end
    end
    chk("wr_ncycles", wb_log.size(), k);
    chk("bresp", b_resp_got, (bad || err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
    chk("bid", b_id_got, id);
  endtask

  task automatic check_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    bit bad;
    bad = burst[1];
    chk("rd_ncycles", wb_log.size(), bad ? 0 : len + 1);
    for (int i = 0; i <= len; i++) begin
      if (!bad && i < wb_log.size()) begin
        chk("rd_adr", wb_log[i].adr, beat_adr(a, size, burst, i));
        chk("rd_sel_we", {wb_log[i].sel, wb_log[i].we}, {4'b1111, 1'b0});
      end
    end
    for (int i = 0; i < r_log.size(); i++) begin
      if (bad) chk("rdata", r_log[i].data, 32'd0);
      else if (i < wb_log.size()) chk("rdata", r_log[i].data, wb_log[i].rdat);
      chk("rresp", r_log[i].resp, bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
      chk("rlast", r_log[i].last, (i == len));
      chk("rid", r_log[i].id, id);
    end
  endtask

  // ---------------- AXI master driver ----------------
  task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = a;
    axi.awlen = len; axi.awsize = size; axi.awburst = burst;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = a;
    axi.arlen = len; axi.arsize = size; axi.arburst = burst;
  endtask

  task automatic hs_aw();
    int g;
    g = 0;
    while (g < 400) begin @(negedge clk_i); g++; if (axi.awready) break; end
    chk("aw_handshake", axi.awready, 1'b1);
    @(posedge clk_i); #1;
    axi.awvalid = 1'b0;
  endtask

  task automatic hs_ar();
    int g;
    g = 0;
    while (g < 400) begin @(negedge clk_i); g++; if (axi.arready) break; end
    chk("ar_handshake", axi.arready, 1'b1);
    @(posedge clk_i); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic w_beats();
    for (int i = 0; i < wq_data.size(); i++) begin
      int g;
      g = 0;
      axi.wvalid = 1'b1; axi.wdata = wq_data[i]; axi.wstrb = wq_strb[i]; axi.wlast = wq_last[i];
      while (g < 400) begin @(negedge clk_i); g++; if (axi.wready) break; end
      chk("w_handshake", axi.wready, 1'b1);
      @(posedge clk_i); #1;
      axi.wvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
    end
  endtask

  task automatic b_get();
    int g;
    g = 0;
    b_seen = 1'b0;
    while (g < 400 && !b_seen) begin
      @(negedge clk_i); g++;
      axi.bready = ($urandom_range(0, 2) != 0);
      if (axi.bvalid && axi.bready) begin
        b_seen = 1'b1; b_resp_got = axi.bresp; b_id_got = axi.bid;
      end
    end
    chk("b_handshake", b_seen, 1'b1);
    @(posedge clk_i); #1;
    axi.bready = 1'b0;
  endtask

  task automatic r_get(input int n);
    int g;
    g = 0;
    r_log.delete();
    while (g < 1000 && r_log.size() < n) begin
      @(negedge clk_i); g++;
      axi.rready = ($urandom_range(0, 2) != 0);
      if (axi.rvalid && axi.rready) begin
        r_rec_t r;
        r.data = axi.rdata; r.resp = axi.rresp; r.last = axi.rlast; r.id = axi.rid;
        r_log.push_back(r);
      end
    end
    chk("r_beats", r_log.size(), n);
    @(posedge clk_i); #1;
    axi.rready = 1'b0;
  endtask

  task automatic run_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    wb_log.delete();
    set_aw(id, a, len, size, burst);
    hs_aw();
    w_beats();
    b_get();
    check_write(id, a, len, size, burst);
  endtask

  task automatic run_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    wb_log.delete();
    set_ar(id, a, len, size, burst);
    hs_ar();
    r_get(len + 1);
    check_read(id, a, len, size, burst);
  endtask

  task automatic fill_w(input logic [7:0] len);
    wq_data.delete(); wq_strb.delete(); wq_last.delete();
    for (int i = 0; i <= len; i++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      wq_last.push_back(($urandom_range(0, 7) == 0) ? (i != len) : (i == len));
    end
  endtask

  task automatic wait_any_ready();
    int g;
    g = 0;
    while (g < 50 && !(axi.arready || axi.awready)) begin @(negedge clk_i); g++; end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    rst_i = 1'b1;
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.rready = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_handshakes", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid}, 5'd0);
    chk("rst_wb_ctrl", {cyc_o, stb_o, we_o, sel_o}, 7'd0);
    chk("rst_adr_dat", {adr_o, dat_o}, 64'd0);
    chk("rst_r_fields", {axi.rdata, axi.rresp, axi.rlast, axi.bresp}, 37'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    // single partial-strobe write
    wq_data = '{32'h1234_ABCD}; wq_strb = '{4'b0011}; wq_last = '{1'b1};
    run_write(4'd5, 32'h8000_0004, 8'd0, 3'd2, BURST_INCR);

    // INCR read of four beats with a slow controller
    ack_min = 5; ack_max = 5;
    run_read(4'd9, 32'h0000_0100, 8'd3, 3'd2, BURST_INCR);
    ack_min = 0; ack_max = 4;

    // first collision: read wins, then the waiting write
    wq_data = '{32'hCAFE_0001}; wq_strb = '{4'b1111}; wq_last = '{1'b1};
    wb_log.delete();
    set_ar(4'd1, 32'h0000_0040, 8'd0, 3'd2, BURST_INCR);
    set_aw(4'd2, 32'h0000_0080, 8'd0, 3'd2, BURST_INCR);
    wait_any_ready();
    chk("collision1_order", {axi.arready, axi.awready}, 2'b10);
    @(posedge clk_i); #1; axi.arvalid = 1'b0;
    r_get(1);
    check_read(4'd1, 32'h0000_0040, 8'd0, 3'd2, BURST_INCR);
    wb_log.delete();
    hs_aw(); w_beats(); b_get();
    check_write(4'd2, 32'h0000_0080, 8'd0, 3'd2, BURST_INCR);

    // second collision: write wins
    wq_data = '{32'hCAFE_0002}; wq_strb = '{4'b1100}; wq_last = '{1'b1};
    wb_log.delete();
    set_ar(4'd3, 32'h0000_00C0, 8'd0, 3'd2, BURST_INCR);
    set_aw(4'd4, 32'h0000_00E0, 8'd0, 3'd2, BURST_INCR);
    wait_any_ready();
    chk("collision2_order", {axi.arready, axi.awready}, 2'b01);
    @(posedge clk_i); #1; axi.awvalid = 1'b0;
    w_beats(); b_get();
    check_write(4'd4, 32'h0000_00E0, 8'd0, 3'd2, BURST_INCR);
    wb_log.delete();
    hs_ar(); r_get(1);
    check_read(4'd3, 32'h0000_00C0, 8'd0, 3'd2, BURST_INCR);

    // zero strobe on beat 0 skips its Wishbone cycle
    wq_data = '{32'h1111_1111, 32'h2222_2222}; wq_strb = '{4'b0000, 4'b1111}; wq_last = '{1'b0, 1'b1};
    run_write(4'd6, 32'h0000_0200, 8'd1, 3'd2, BURST_INCR);

    // WRAP read answered locally with SLVERR
    run_read(4'd7, 32'h0000_0300, 8'd1, 3'd2, BURST_WRAP);

    // early wlast on beat 0 of a two-beat write
    wq_data = '{32'h3333_3333, 32'h4444_4444}; wq_strb = '{4'b1111, 4'b1111}; wq_last = '{1'b1, 1'b1};
    run_write(4'd8, 32'h0000_0400, 8'd1, 3'd2, BURST_INCR);

    // reset while a Wishbone cycle is open
    ack_min = 20; ack_max = 20;
    wb_log.delete();
    set_ar(4'd10, 32'h0000_0500, 8'd2, 3'd2, BURST_INCR);
    hs_ar();
    g = 0;
    while (g < 20 && !cyc_o) begin @(posedge clk_i); #1; g++; end
    chk("mid_reset_cyc_open", cyc_o, 1'b1);
    @(negedge clk_i); rst_i = 1'b1; #1;
    chk("mid_reset_wb_drop", {cyc_o, stb_o, we_o}, 3'd0);
    chk("mid_reset_axi_idle", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid}, 5'd0);
    @(negedge clk_i); rst_i = 1'b0;
    ack_min = 0; ack_max = 4;
    @(posedge clk_i); #1;
    run_read(4'd11, 32'h0000_0600, 8'd1, 3'd2, BURST_INCR);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] a;
      logic [3:0]  id;
      int          bsel;
      len  = 8'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 3));
      bsel = $urandom_range(0, 9);
      burst = (bsel < 6) ? BURST_INCR : (bsel < 8) ? BURST_FIXED : (bsel == 8) ? BURST_WRAP : 2'b11;
      a  = $urandom;
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        fill_w(len);
        run_write(id, a, len, size, burst);
      end else begin
        run_read(id, a, len, size, burst);
      end
    end

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
